// File: rtl/wb_reg_file_if.sv
// Bus bundle between the MEM/WB pipeline register / ID stage and the
// write-back register file. master drives the pipeline-side inputs,
// slave is the register file itself.
interface wb_reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              Reg_w;
  logic              Mem_to_reg;
  logic [DATA_W-1:0] ALU_Result;
  logic [DATA_W-1:0] MemReadData;
  logic [ADDR_W-1:0] RdAddr;
  logic [ADDR_W-1:0] RsAddr;
  logic [ADDR_W-1:0] RtAddr;
  logic [DATA_W-1:0] RsData;
  logic [DATA_W-1:0] RtData;
  logic [DATA_W-1:0] WB_Data;
  logic [CNT_W-1:0]  WB_Count;

  modport master (
    output Reg_w, Mem_to_reg, ALU_Result, MemReadData, RdAddr, RsAddr, RtAddr,
    input  RsData, RtData, WB_Data, WB_Count
  );

  modport slave (
    input  Reg_w, Mem_to_reg, ALU_Result, MemReadData, RdAddr, RsAddr, RtAddr,
    output RsData, RtData, WB_Data, WB_Count
  );
endinterface

// File: rtl/wb_reg_file.sv
// Write-back stage and 2^ADDR_W-entry architectural register file.
// Selects ALU/load data, commits it at posedge, serves two combinational
// read ports and counts committed writes (wrapping counter).
// Optional macro WB_BYPASS_EN: read ports return WB_Data in the same cycle
// when their address matches a pending commit.
module wb_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic         clk,
  input logic         rst,
  wb_reg_file_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  // Write-back mux; purely combinational, unaffected by reset.
  always_comb begin
    wb_data = bus.Mem_to_reg ? bus.MemReadData : bus.ALU_Result;
  end

  // Next-state: one commit per cycle, register 0 never written.
  always_comb begin
    commit = bus.Reg_w && (bus.RdAddr != '0) && !rst;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (commit) begin
      regs_d[bus.RdAddr] = wb_data;
      cnt_d              = cnt_q + CNT_W'(1);
    end
    regs_d[0] = '0;
  end

  // State update; async reset clears every register and the counter at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports; address 0 and reset force zero, optional same-cycle bypass.
  always_comb begin
    bus.RsData = regs_q[bus.RsAddr];
    bus.RtData = regs_q[bus.RtAddr];
`ifdef WB_BYPASS_EN
    if (commit && (bus.RsAddr == bus.RdAddr)) bus.RsData = wb_data;
    if (commit && (bus.RtAddr == bus.RdAddr)) bus.RtData = wb_data;
`endif
    if (rst || (bus.RsAddr == '0)) bus.RsData = '0;
    if (rst || (bus.RtAddr == '0)) bus.RtData = '0;
  end

  // Output mirrors.
  always_comb begin
    bus.WB_Data  = wb_data;
    bus.WB_Count = cnt_q;
  end
endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: directed table, hand-written corner
// sequences (reset, hazard, counter wrap) and randomized traffic against a
// simple array-based reference model. Counter is built with CNT_W=4.
module tb_wb_reg_file;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  wb_reg_file #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Reference model: plain register array and a modular commit count.
  logic [31:0] mregs [32];
  int unsigned mcnt;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mcnt = 0;
  endtask

  function automatic logic [31:0] exp_wb();
    return bus.Mem_to_reg ? bus.MemReadData : bus.ALU_Result;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (bus.Reg_w && bus.RdAddr == a) return exp_wb();
`endif
    return mregs[a];
  endfunction

  task automatic model_edge();
    if (!rst && bus.Reg_w && bus.RdAddr != 5'd0) begin
      mregs[bus.RdAddr] = exp_wb();
      mcnt = (mcnt + 1) % 16;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.Reg_w       = w;
    bus.Mem_to_reg  = m2r;
    bus.ALU_Result  = alu;
    bus.MemReadData = mem;
    bus.RdAddr      = rd;
    bus.RsAddr      = rs;
    bus.RtAddr      = rt;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_wb"}, bus.WB_Data, exp_wb());
    chk({tag, "_rs"}, bus.RsData, exp_read(bus.RsAddr));
    chk({tag, "_rt"}, bus.RtData, exp_read(bus.RtAddr));
    chk({tag, "_cnt"}, 32'(bus.WB_Count), mcnt);
  endtask

  typedef struct {
    logic        w;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_wb;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    // Expectations are the pre-edge outputs given all prior rows committed.
    tbl[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd5,  5'd0, 5'd0,
               32'h1234_5678, 32'h0, 32'h0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd31, 5'd5, 5'd5,
               32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 32'd1};
    tbl[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd31, 5'd0,
               32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 32'd2};
    tbl[3] = '{1'b0, 1'b0, 32'h77, 32'h0, 5'd7, 5'd0, 5'd31,
               32'h77, 32'h0, 32'hDEAD_BEEF, 32'd2};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h55, 5'd3, 5'd7, 5'd5,
               32'h55, 32'h0, 32'h1234_5678, 32'd2};

    drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
    model_clear();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].w, tbl[i].m2r, tbl[i].alu, tbl[i].mem, tbl[i].rd, tbl[i].rs, tbl[i].rt);
      #2;
      chk($sformatf("tbl%0d_wb", i), bus.WB_Data, tbl[i].e_wb);
      chk($sformatf("tbl%0d_rs", i), bus.RsData, tbl[i].e_rs);
      chk($sformatf("tbl%0d_rt", i), bus.RtData, tbl[i].e_rt);
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.WB_Count), tbl[i].e_cnt);
      tick();
    end

    // Same-cycle hazard on reg 9.
    drive(1'b1, 1'b0, 32'h0000_0011, '0, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 32'hA5A5_A5A5, '0, 5'd9, 5'd9, 5'd9);
    #2;
`ifdef WB_BYPASS_EN
    chk("haz_rs", bus.RsData, 32'hA5A5_A5A5);
    chk("haz_rt", bus.RtData, 32'hA5A5_A5A5);
`else
    chk("haz_rs", bus.RsData, 32'h0000_0011);
    chk("haz_rt", bus.RtData, 32'h0000_0011);
`endif
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd9, 5'd9, 5'd9);
    #2;
    chk("haz_after_rs", bus.RsData, 32'hA5A5_A5A5);

    // Asynchronous reset mid-cycle with registers preloaded.
    drive(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, 5'd4, 5'd5, 5'd31);
    #2;
    chk("pre_rst_rs", bus.RsData, 32'h1234_5678);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_rs", bus.RsData, 32'h0);
    chk("rst_rt", bus.RtData, 32'h0);
    chk("rst_cnt", 32'(bus.WB_Count), 32'h0);
    chk("rst_wb", bus.WB_Data, 32'h0BAD_F00D);
    tick();
    rst = 1'b0;

    // Counter wrap: 17 commits on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 32'(i * 3 + 1), '0, 5'((i % 31) + 1), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 5'd12, 5'd0);
    #2;
    chk("wrap_cnt", 32'(bus.WB_Count), 32'd1);
    chk("wrap_r12", bus.RsData, 32'd34);
    drive(1'b1, 1'b0, 32'h0000_CAFE, '0, 5'd12, 5'd12, 5'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0000_BEEF, '0, 5'd12, 5'd12, 5'd12);
    #2;
    chk("prerst_r12", bus.RsData == 32'h0000_BEEF ? 32'h0000_CAFE : bus.RsData,
        32'h0000_CAFE);
    rst = 1'b1;
    model_clear();
    #1;
    chk("wrst_rs", bus.RsData, 32'h0);
    chk("wrst_rt", bus.RtData, 32'h0);
    chk("wrst_cnt", 32'(bus.WB_Count), 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 5'd12, 5'd12, 5'd0);
    #2;
    chk("lost_r12", bus.RsData, 32'h0);
    chk("lost_cnt", 32'(bus.WB_Count), 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
            5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      #2;
      chk_model($sformatf("rnd%0d", i));
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
